spiker_result_buffer: RTL
=========================

# spiker_result_buffer

- Parametrised successor to the single-register spike result writer.
- Captures spike-result words from the spiker core into a DEPTH-entry FIFO so software may drain them at its own pace.
- Raises a one-cycle batch-notification strobe every BATCH accepted samples, and flags overflow when the core outpaces software.
- Sits between the spiker core output and the adapter register file (result, status and notification fields).

## Interface

Parameters:
- WIDTH, 32, spike-result word width.
- DEPTH, 8, FIFO entries; power of two, ≥2.
- BATCH, 15, accepted samples per batch notification; ≥1.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- data_i  input  WIDTH  spike-result word from core.
- sample_i  input  1  core presents data_i this cycle.
- ready_o  output  1  buffer can accept; equals !full.
- core_ready_i  input  1  core status ready.
- status_ready_o  output  1  core_ready_i registered once, to register file.
- pop_i  input  1  software read strobe of the head entry.
- rd_data_o  output  WIDTH  head entry, first-word-fall-through; 0 when empty.
- rd_valid_o  output  1  FIFO not empty.
- rd_ts_o  output  16  head entry timestamp (see Configuration).
- count_o  output  $clog2(DEPTH)+1  current occupancy.
- batch_d_o  output  1  batch-notification data, held at 1 once set until clear_i.
- batch_de_o  output  1  one-cycle register write-enable accompanying batch_d_o.
- overflow_o  output  1  sticky dropped-sample flag.
- clear_i  input  1  synchronous flush from software.

## Operation

- Push accepted = sample_i && (!full || pop accepted same cycle); pushes data_i at tail.
- Pop accepted = pop_i && !empty; advances head. pop_i when empty is ignored, with no state change.
- Push with full and no pop: data dropped, overflow_o set; FIFO and batch counter unchanged.
- Simultaneous push+pop: count_o unchanged and both pointers advance. When empty, the push is stored and pop is ignored.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from count_o (count_o==DEPTH / count_o==0).
- Batch counter, $clog2(BATCH)+1 bits wide, increments on each accepted push.
- When an accepted push occurs at counter==BATCH-1:
  - counter returns to 0;
  - next cycle batch_de_o=1 for exactly one cycle and batch_d_o becomes 1.
- BATCH=1: every accepted push produces a strobe.
- clear_i has priority over push and pop in the same cycle. It:
  - empties the FIFO (pointers 0);
  - zeroes the batch counter;
  - clears overflow_o and batch_d_o;
  - suppresses batch_de_o for that cycle.
- Reset mid-operation discards all contents immediately (asynchronous).

## Timing

- Reset values:
  - ready_o=1, status_ready_o=0, rd_data_o=0, rd_valid_o=0, rd_ts_o=0, count_o=0;
  - batch_d_o=0, batch_de_o=0, overflow_o=0.
- Push latency: a word pushed at edge N is visible on rd_data_o, with rd_valid_o=1, after edge N (fall-through from empty: 1 cycle).
- count_o, ready_o, rd_valid_o and overflow_o update on the edge of the accepting/rejecting event.
- ready_o has no combinational path from pop_i or sample_i.
- batch_de_o asserts 1 cycle after the BATCH-th accepted push.
- status_ready_o lags core_ready_i by 1 cycle.

## Configuration

- SPIKER_RESULT_TS_EN defined:
  - a free-running 16-bit cycle counter (reset 0, wraps at 0xFFFF) is stored alongside each pushed word;
  - rd_ts_o shows the head entry's capture cycle.
- Undefined: no timestamp storage or counter; rd_ts_o tied to 0. All other behaviour is identical.

## Test plan

- Reset, then push 0xA5A5_0001..0xA5A5_0003 on consecutive cycles, then pop 3 times:
  - rd_data_o returns the words in order;
  - count_o goes 1,2,3 then 2,1,0;
  - rd_valid_o falls after the 3rd pop.
- DEPTH=8: 9 pushes with no pops:
  - ready_o=0 after the 8th push;
  - 9th dropped, overflow_o=1, count_o=8;
  - pops return the first 8 words.
- Full FIFO with sample_i and pop_i in the same cycle:
  - push accepted, overflow_o stays 0, count_o stays 8;
  - new word emerges last.
- BATCH=15: 30 accepted pushes interleaved with pops:
  - batch_de_o pulses exactly twice, 1 cycle after push 15 and push 30;
  - batch_d_o=1 until clear_i; clear_i then gives count_o=0, overflow_o=0, batch_d_o=0.
- clear_i asserted with sample_i in the same cycle: FIFO empty afterwards and batch counter 0. A further 15 pushes trigger one batch_de_o.
- With SPIKER_RESULT_TS_EN: push at cycles 5 and 9 after reset, so rd_ts_o reads 5 then 9 across pops. Without the macro, rd_ts_o=0 throughout.

Source files
------------

// File: rtl/spiker_result_buffer.sv
// rtl/spiker_result_buffer.sv - FIFO buffer for spike-result words with batch notification and overflow flag.
// Optional per-entry capture timestamp enabled by SPIKER_RESULT_TS_EN.
module spiker_result_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int BATCH = 15
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       sample_i,
    output logic                       ready_o,
    input  logic                       core_ready_i,
    output logic                       status_ready_o,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       rd_valid_o,
    output logic [15:0]                rd_ts_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       batch_d_o,
    output logic                       batch_de_o,
    output logic                       overflow_o,
    input  logic                       clear_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BATCH) + 1;
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [BW-1:0] BATCH_LAST = BW'(BATCH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [BW-1:0]    batch_cnt_q, batch_cnt_d;
    logic             batch_d_q, batch_d_d;
    logic             batch_de_q, batch_de_d;
    logic             overflow_q, overflow_d;
    logic             status_ready_q, status_ready_d;

    logic full;
    logic empty;
    logic pop_acc;
    logic push_acc;

    // Full/empty come from the registered count so ready_o never sees pop_i/sample_i.
    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign pop_acc  = pop_i && !empty;
    assign push_acc = sample_i && (!full || pop_acc);

    always_comb begin
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        batch_cnt_d    = batch_cnt_q;
        batch_d_d      = batch_d_q;
        batch_de_d     = 1'b0;
        overflow_d     = overflow_q;
        status_ready_d = core_ready_i;

        if (clear_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            batch_cnt_d = '0;
            batch_d_d   = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            if (push_acc) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + AW'(1);
                if (batch_cnt_q == BATCH_LAST) begin
                    batch_cnt_d = '0;
                    batch_de_d  = 1'b1;
                    batch_d_d   = 1'b1;
                end else begin
                    batch_cnt_d = batch_cnt_q + BW'(1);
                end
            end
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push_acc) - CW'(pop_acc);
            if (sample_i && !push_acc) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            batch_cnt_q    <= '0;
            batch_d_q      <= 1'b0;
            batch_de_q     <= 1'b0;
            overflow_q     <= 1'b0;
            status_ready_q <= 1'b0;
        end else begin
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            batch_cnt_q    <= batch_cnt_d;
            batch_d_q      <= batch_d_d;
            batch_de_q     <= batch_de_d;
            overflow_q     <= overflow_d;
            status_ready_q <= status_ready_d;
        end
    end

`ifdef SPIKER_RESULT_TS_EN
    logic [15:0] ts_cnt_q, ts_cnt_d;
    logic [15:0] ts_mem_q [DEPTH];
    logic [15:0] ts_mem_d [DEPTH];

    // The cycle counter free-runs; clear_i only affects queue contents.
    always_comb begin
        ts_cnt_d = ts_cnt_q + 16'd1;
        ts_mem_d = ts_mem_q;
        if (!clear_i && push_acc) begin
            ts_mem_d[wr_ptr_q] = ts_cnt_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ts_cnt_q <= 16'd0;
            for (int i = 0; i < DEPTH; i++) begin
                ts_mem_q[i] <= 16'd0;
            end
        end else begin
            ts_cnt_q <= ts_cnt_d;
            ts_mem_q <= ts_mem_d;
        end
    end

    assign rd_ts_o = empty ? 16'd0 : ts_mem_q[rd_ptr_q];
`else
    assign rd_ts_o = 16'd0;
`endif

    assign ready_o        = !full;
    assign rd_valid_o     = !empty;
    assign rd_data_o      = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o        = count_q;
    assign batch_d_o      = batch_d_q;
    assign batch_de_o     = batch_de_q;
    assign overflow_o     = overflow_q;
    assign status_ready_o = status_ready_q;

endmodule
